// File: rtl/reg_file_8x8.sv
// 8-entry x 8-bit register file: one synchronous write port, two combinational read ports, r0 hardwired to zero.
// Latency: writes land on the rising clk edge; reads are combinational with write-first forwarding of same-cycle writes.
// Backpressure: none; a write is accepted on every edge where we is high, and reads are always available.
module reg_file_8x8 #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];

    // A write to a non-zero index is the only thing that changes the array.
    logic wr_hit;
    assign wr_hit = we && (waddr != '0);

    // Next-state of the array: hold, overwrite the addressed entry, and pin r0 to zero.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_hit) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    // Storage: async clear on rst_n low; edges during reset are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Port A read: r0 reads zero, otherwise forward pending write data on an address match.
    // Forwarding is suppressed while in reset so every address reads zero.
    always_comb begin
        rdata_a = '0;
        if (raddr_a != '0) begin
            if (rst_n && wr_hit && (waddr == raddr_a)) begin
                rdata_a = wdata;
            end else begin
                rdata_a = regs_q[raddr_a];
            end
        end
    end

    // Port B read: identical to port A, evaluated independently.
    always_comb begin
        rdata_b = '0;
        if (raddr_b != '0) begin
            if (rst_n && wr_hit && (waddr == raddr_b)) begin
                rdata_b = wdata;
            end else begin
                rdata_b = regs_q[raddr_b];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_8x8.sv
module tb_reg_file_8x8;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] raddr_a;
    logic [2:0] raddr_b;
    logic [7:0] rdata_a;
    logic [7:0] rdata_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] a;
        logic [7:0] b;
    } sb_t;

    sb_t        sb_q[$];
    logic [7:0] mdl [8];

    reg_file_8x8 #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input string tag, input logic [7:0] ea, input logic [7:0] eb);
        sb_t e;
        e.tag = tag;
        e.a   = ea;
        e.b   = eb;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp();
        sb_t e;
        if (sb_q.size() == 0) begin
            check8("sb_underflow", 8'd0, 8'd1);
        end else begin
            e = sb_q.pop_front();
            check8({e.tag, "_a"}, rdata_a, e.a);
            check8({e.tag, "_b"}, rdata_b, e.b);
        end
    endtask

    // Set read addresses, queue the expected data, let the combinational path settle, compare.
    task automatic rd_chk(input string tag, input logic [2:0] ra, input logic [2:0] rb,
                          input logic [7:0] ea, input logic [7:0] eb);
        raddr_a = ra;
        raddr_b = rb;
        push_exp(tag, ea, eb);
        #1;
        pop_cmp();
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        logic [7:0] ea;
        logic [7:0] eb;
        clk     = 1'b0;
        rst_n   = 1'b0;
        we      = 1'b0;
        waddr   = 3'd0;
        wdata   = 8'h00;
        raddr_a = 3'd0;
        raddr_b = 3'd0;

        #3;
        rd_chk("rst_state", 3'd3, 3'd5, 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset clears a written register between clock edges
        wr(3'd3, 8'hA5);
        rd_chk("r3_written", 3'd3, 3'd0, 8'hA5, 8'h00);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        rd_chk("rst_async", 3'd3, 3'd3, 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        rd_chk("rst_release", 3'd3, 3'd3, 8'h00, 8'h00);

        // Basic writes on consecutive edges
        wr(3'd1, 8'h11);
        wr(3'd2, 8'h22);
        wr(3'd7, 8'hFF);
        rd_chk("basic_1_7", 3'd1, 3'd7, 8'h11, 8'hFF);
        rd_chk("basic_2", 3'd2, 3'd2, 8'h22, 8'h22);

        // Register 0 ignores writes and never forwards
        @(negedge clk);
        we    = 1'b1;
        waddr = 3'd0;
        wdata = 8'h5A;
        rd_chk("zero_pre", 3'd0, 3'd1, 8'h00, 8'h11);
        @(posedge clk);
        #1;
        we = 1'b0;
        rd_chk("zero_post", 3'd0, 3'd0, 8'h00, 8'h00);

        // Write-first bypass on both ports
        wr(3'd4, 8'h10);
        rd_chk("r4_old", 3'd4, 3'd4, 8'h10, 8'h10);
        @(negedge clk);
        we    = 1'b1;
        waddr = 3'd4;
        wdata = 8'h99;
        rd_chk("byp_pre", 3'd4, 3'd4, 8'h99, 8'h99);
        rd_chk("byp_other", 3'd4, 3'd2, 8'h99, 8'h22);
        @(posedge clk);
        #1;
        we = 1'b0;
        rd_chk("byp_post", 3'd4, 3'd4, 8'h99, 8'h99);

        // we=0 leaves the addressed register untouched
        @(negedge clk);
        we    = 1'b0;
        waddr = 3'd5;
        wdata = 8'hCC;
        rd_chk("wegate_pre", 3'd5, 3'd0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rd_chk("wegate_post", 3'd5, 3'd5, 8'h00, 8'h00);

        // Back-to-back writes: last edge wins
        wr(3'd2, 8'h33);
        wr(3'd2, 8'h44);
        rd_chk("b2b", 3'd2, 3'd1, 8'h44, 8'h11);

        // Edge inside reset window with we=1 is ignored
        @(negedge clk);
        rst_n = 1'b0;
        we    = 1'b1;
        waddr = 3'd6;
        wdata = 8'h77;
        rd_chk("rst_mid", 3'd1, 3'd7, 8'h00, 8'h00);
        @(posedge clk);
        @(negedge clk);
        we    = 1'b0;
        rst_n = 1'b1;
        #1;
        rd_chk("rst_mid_r6", 3'd6, 3'd4, 8'h00, 8'h00);

        // Random traffic against a reference array (all zero after the reset above)
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            we      = 1'($urandom_range(0, 1));
            waddr   = 3'($urandom_range(0, 7));
            wdata   = 8'($urandom_range(0, 255));
            raddr_a = 3'($urandom_range(0, 7));
            raddr_b = (n % 4 == 0) ? raddr_a : 3'($urandom_range(0, 7));
            ea = (raddr_a == 3'd0) ? 8'h00 :
                 (we && waddr == raddr_a) ? wdata : mdl[raddr_a];
            eb = (raddr_b == 3'd0) ? 8'h00 :
                 (we && waddr == raddr_b) ? wdata : mdl[raddr_b];
            push_exp("rand", ea, eb);
            #1;
            pop_cmp();
            @(posedge clk);
            if (we && waddr != 3'd0) mdl[waddr] = wdata;
        end
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_chk("final_sweep", 3'(i), 3'(7 - i), mdl[i], mdl[7 - i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_8x8.md
Name: reg_file_8x8

Overview:
8-entry general-purpose register file for the CPU datapath. Built from per-bit edge-triggered storage, one clock.
- One synchronous write port and two combinational read ports.
- Sits between the decode stage (addresses) and the ALU (operands); ALU results return on the write port.
- Register 0 is hardwired to zero.

Parameters:
WIDTH, 8, data bits per register
DEPTH, 8, number of registers (fixed at 8; not re-sized)
ADDR_W, 3, address width, equals log2(DEPTH)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
we  input  1  write enable, sampled on rising clk
waddr  input  ADDR_W  write register index
wdata  input  WIDTH  write data
raddr_a  input  ADDR_W  read port A index
raddr_b  input  ADDR_W  read port B index
rdata_a  output  WIDTH  read port A data (combinational)
rdata_b  output  WIDTH  read port B data (combinational)

Behaviour:
- Clocking/reset: single clock clk. Reset is asynchronous and active-low, on rst_n.
- Reset: rst_n low immediately clears all 8 registers to 8'h00, independent of clk. rdata_a and rdata_b then read 8'h00 for every address.
- Reset mid-write: a rising clk while rst_n is low is ignored; registers stay 0.
- Reset release: the first rising clk with rst_n high may write.
- Write timing:
  - On rising clk with rst_n high and we=1, reg[waddr] <= wdata.
  - Write latency is one edge: the stored value is visible through the array path after that edge.
- we=0: no register changes; wdata and waddr are don't-care.
- Register 0:
  - Writes to address 0 are discarded.
  - rdata_x for raddr_x=0 is always 8'h00, including during bypass.
- Reads:
  - Purely combinational from the addresses; no read latency.
  - Both ports are independent and may address the same register.
- Write-first bypass:
  - Condition: we=1, waddr!=0 and raddr_x==waddr in the same cycle.
  - rdata_x = wdata (combinational forward) before the edge, so a same-cycle consumer sees new data.
  - Applies to each port independently. Both ports may bypass simultaneously.
- Simultaneous read/write of different registers: reads return old contents of their own registers, unaffected.
- Back-to-back writes to the same register: the last edge wins. No hazard logic beyond bypass.
- X-handling: the bench keeps addresses known. Unknown waddr with we=1 is illegal (no defined result).
- No other outputs, no status flags. Data is unsigned; no arithmetic in the block.

Test Plan:
- Reset clear: write 8'hA5 to r3, drop rst_n with clk idle -> rdata_a(raddr_a=3)=8'h00 immediately; after release, r3 still 8'h00.
- Basic write/read:
  - Stimulus: write r1=8'h11, r2=8'h22, r7=8'hFF on consecutive edges.
  - Response: raddr_a=1, raddr_b=7 gives 8'h11 and 8'hFF; raddr_a=2 gives 8'h22.
- Zero register: we=1, waddr=0, wdata=8'h5A, edge -> rdata_a(0)=8'h00. Same cycle with raddr_a=0 also 8'h00 (no bypass).
- Bypass:
  - Stimulus: r4 holds 8'h10; set we=1, waddr=4, wdata=8'h99, raddr_a=raddr_b=4 before the edge.
  - Response: both ports show 8'h99 pre-edge; after the edge with we=0, both still 8'h99.
- we gating: we=0, waddr=5, wdata=8'hCC, 3 edges -> r5 remains its prior value 8'h00.
- Reset mid-operation: rst_n low during a cycle with we=1, waddr=6, wdata=8'h77, and a rising clk inside the reset window -> r6=8'h00 after release.
